// File: rtl/rom_seq_reader_pkg.sv
// Shared definitions for the sequential ROM reader: FSM state encodings and
// the default memory-map constants (boot ROM base and depth).
package rom_seq_reader_pkg;

  typedef enum logic [1:0] {
    ROM_ST_IDLE  = 2'd0,
    ROM_ST_FETCH = 2'd1,
    ROM_ST_RESP  = 2'd2
  } rom_state_e;

  localparam int ROM_BOOT_BASE     = 'h40;
  localparam int ROM_DEFAULT_DEPTH = 1024;

endpackage

// File: rtl/rom_byte_array.sv
// Byte-wide ROM storage exposing PORTS combinational read ports.
// Each port returns mem[addr mod DEPTH] plus an in-range flag.
module rom_byte_array
  import rom_seq_reader_pkg::*;
#(
  parameter           FILENAME = "/dev/null",
  parameter int       ADDR_W   = 16,
  parameter int       DEPTH    = ROM_DEFAULT_DEPTH,
  parameter int       PORTS    = 1
) (
  input  logic [PORTS-1:0][ADDR_W-1:0] addr,
  output logic [PORTS-1:0][7:0]        data,
  output logic [PORTS-1:0]             in_range
);

  localparam int              IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] WIDE_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [7:0] mem [DEPTH];

  // One extra address bit keeps DEPTH == 2**ADDR_W representable.
  always_comb begin
    data     = '0;
    in_range = '0;
    for (int p = 0; p < PORTS; p++) begin
      in_range[p] = ({1'b0, addr[p]} < WIDE_DEPTH);
      data[p]     = mem[IDX_W'({1'b0, addr[p]} % WIDE_DEPTH)];
    end
  end

endmodule

// File: rtl/rom_seq_reader.sv
// Clocked byte-addressed ROM reader: accepts a byte address, assembles a
// little-endian word over WORD_BYTES/BYTES_PER_CYCLE fetch cycles and returns
// it on a valid/ready port. Define ROM_BOUNDS_CHECK_EN to zero out-of-range
// bytes and flag rsp_err; otherwise offsets wrap modulo DEPTH.
module rom_seq_reader
  import rom_seq_reader_pkg::*;
#(
  parameter                    FILENAME        = "/dev/null",
  parameter int                ADDR_W          = 16,
  parameter int                WORD_BYTES      = 4,
  parameter int                BYTES_PER_CYCLE = 1,
  parameter int                DEPTH           = ROM_DEFAULT_DEPTH,
  parameter logic [ADDR_W-1:0] BASE_ADDR       = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*WORD_BYTES-1:0] rsp_data,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int CNT_W = $clog2(WORD_BYTES + 1);

  rom_state_e                              state, state_nxt;
  logic [ADDR_W-1:0]                       eaddr;
  logic [CNT_W-1:0]                        cnt;
  logic [8*WORD_BYTES-1:0]                 word;
  logic [BYTES_PER_CYCLE-1:0][ADDR_W-1:0]  rd_addr;
  logic [BYTES_PER_CYCLE-1:0][7:0]         rd_data;
  logic [BYTES_PER_CYCLE-1:0][7:0]         rd_byte;
  logic [BYTES_PER_CYCLE-1:0]              rd_in_range;
  logic                                    accept;
  logic                                    fetch_last;

  assign req_ready  = rst_n && (state == ROM_ST_IDLE);
  assign accept     = req_valid && req_ready;
  assign fetch_last = (cnt + CNT_W'(BYTES_PER_CYCLE)) == CNT_W'(WORD_BYTES);
  assign rsp_valid  = (state == ROM_ST_RESP);
  assign busy       = (state != ROM_ST_IDLE);
  assign rsp_data   = word;

  always_comb begin
    rd_addr = '0;
    for (int p = 0; p < BYTES_PER_CYCLE; p++)
      rd_addr[p] = eaddr + ADDR_W'(cnt) + ADDR_W'(p);
  end

  rom_byte_array #(
    .FILENAME (FILENAME),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .PORTS    (BYTES_PER_CYCLE)
  ) u_array (
    .addr     (rd_addr),
    .data     (rd_data),
    .in_range (rd_in_range)
  );

  always_comb begin
    rd_byte = rd_data;
`ifdef ROM_BOUNDS_CHECK_EN
    for (int p = 0; p < BYTES_PER_CYCLE; p++)
      if (!rd_in_range[p]) rd_byte[p] = 8'h00;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ROM_ST_IDLE:  if (accept)     state_nxt = ROM_ST_FETCH;
      ROM_ST_FETCH: if (fetch_last) state_nxt = ROM_ST_RESP;
      ROM_ST_RESP:  if (rsp_ready)  state_nxt = ROM_ST_IDLE;
      default:                      state_nxt = ROM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ROM_ST_IDLE;
    else        state <= state_nxt;
  end

  // Word assembly: each fetch cycle drops BYTES_PER_CYCLE bytes at lane cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eaddr <= '0;
      cnt   <= '0;
      word  <= '0;
    end else if (accept) begin
      eaddr <= req_addr - BASE_ADDR;
      cnt   <= '0;
      word  <= '0;
    end else if (state == ROM_ST_FETCH) begin
      for (int p = 0; p < BYTES_PER_CYCLE; p++)
        word[8*(int'(cnt)+p) +: 8] <= rd_byte[p];
      cnt <= cnt + CNT_W'(BYTES_PER_CYCLE);
    end
  end

`ifdef ROM_BOUNDS_CHECK_EN
  logic err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      err <= 1'b0;
    else if (accept)                 err <= 1'b0;
    else if (state == ROM_ST_FETCH)  err <= err | ~(&rd_in_range);
  end

  assign rsp_err = err;
`else
  logic unused_in_range;
  assign unused_in_range = &{1'b0, rd_in_range};
  assign rsp_err         = 1'b0;
`endif

endmodule

// File: tb/tb_rom_seq_reader.sv
// Randomised bench for rom_seq_reader: two instances (1 and 2 bytes per cycle)
// share request/response stimulus and are checked against a byte-level model.
module tb_rom_seq_reader;

  localparam int          DEPTH = 1024;
  localparam logic [15:0] BASE  = 16'h40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        rsp_ready;

  logic        req_ready_a, rsp_valid_a, rsp_err_a, busy_a;
  logic [31:0] rsp_data_a;
  logic        req_ready_b, rsp_valid_b, rsp_err_b, busy_b;
  logic [31:0] rsp_data_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rom_seq_reader #(
    .ADDR_W(16), .WORD_BYTES(4), .BYTES_PER_CYCLE(1), .DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_addr(req_addr), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_a), .rsp_err(rsp_err_a), .busy(busy_a)
  );

  rom_seq_reader #(
    .ADDR_W(16), .WORD_BYTES(4), .BYTES_PER_CYCLE(2), .DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_addr(req_addr), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_b), .rsp_err(rsp_err_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
  endtask

  // Image byte at offset o is o mod 256.
  function automatic logic [31:0] model_word(input logic [15:0] addr, output logic err);
    logic [31:0] w = '0;
    err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int off = (int'(addr) - int'(BASE) + k) & 'hFFFF;
      int b;
      if (off < DEPTH) b = off % 256;
      else begin
`ifdef ROM_BOUNDS_CHECK_EN
        b   = 0;
        err = 1'b1;
`else
        b = (off % DEPTH) % 256;
`endif
      end
      w |= 32'(b) << (8*k);
    end
    return w;
  endfunction

  task automatic run_txn(input logic [15:0] addr, input int hold, input bit poke);
    logic [31:0] exp_w;
    logic        exp_e;
    int          lat_a = -1;
    int          lat_b = -1;
    exp_w = model_word(addr, exp_e);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = ~addr;
    check("accept_busy", {busy_a, busy_b, req_ready_a, req_ready_b}, 4'b1100);
    for (int k = 1; k <= 20 && (lat_a < 0 || lat_b < 0); k++) begin
      @(posedge clk); #1;
      if (rsp_valid_a && lat_a < 0) lat_a = k;
      if (rsp_valid_b && lat_b < 0) lat_b = k;
    end
    check("latency_a", 64'(lat_a), 64'd4);
    check("latency_b", 64'(lat_b), 64'd2);
    check("data_a", rsp_data_a, exp_w);
    check("data_b", rsp_data_b, exp_w);
    check("err_a", rsp_err_a, exp_e);
    check("err_b", rsp_err_b, exp_e);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (poke) begin
        req_valid = 1'b1;
        req_addr  = addr ^ 16'h0005;
      end
      @(posedge clk); #1;
      check("hold_data", {rsp_data_a, rsp_data_b}, {exp_w, exp_w});
      check("hold_ctl", {rsp_valid_a, rsp_valid_b, req_ready_a, req_ready_b}, 4'b1100);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("post_hs_ctl", {rsp_valid_a, rsp_valid_b, busy_a, busy_b, req_ready_a, req_ready_b},
          6'b000011);
    check("post_hs_data", {rsp_data_a, rsp_data_b}, {exp_w, exp_w});
    @(posedge clk); #1;
    check("stay_idle", {busy_a, busy_b}, 2'b00);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      dut_a.u_array.mem[i] = 8'(i);
      dut_b.u_array.mem[i] = 8'(i);
    end
    #1;
    check("reset_ctl", {rsp_valid_a, rsp_valid_b, busy_a, busy_b, req_ready_a, req_ready_b},
          6'b000000);
    check("reset_out", {rsp_data_a, rsp_data_b, rsp_err_a, rsp_err_b}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {req_ready_a, req_ready_b, busy_a, busy_b}, 4'b1100);

    run_txn(16'h0040, 0, 1'b0);
    run_txn(16'h0043, 0, 1'b0);
    run_txn(16'h0040 + 16'd1022, 1, 1'b0);
    run_txn(16'h0040 + 16'd1023, 0, 1'b0);
    run_txn(16'h003F, 0, 1'b0);
    run_txn(16'h0050, 10, 1'b1);

    // Reset during the second fetch cycle aborts the word.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 16'h0040;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midreset_ctl", {rsp_valid_a, rsp_valid_b, busy_a, busy_b, req_ready_a}, 5'b00000);
    check("midreset_data", rsp_data_a, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("after_reset_idle", {rsp_valid_a, rsp_valid_b, busy_a, busy_b}, 4'b0000);
    run_txn(16'h0040, 0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      logic [15:0] a;
      if (t % 3 == 0) a = 16'($urandom_range(0, 65535));
      else            a = BASE + 16'($urandom_range(0, DEPTH + 8));
      run_txn(a, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
